// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master DMEM arbiter.
// Arbitration mode is selected in arb_pick2 by the DMEM_ARB_RR_EN macro.
package dmem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic [1:0] BYTE_SEL_BYTE = 2'b00;
  localparam logic [1:0] BYTE_SEL_HALF = 2'b01;
  localparam logic [1:0] BYTE_SEL_WORD = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_RESP = 1'b1
  } state_t;

  typedef logic [NUM_MASTERS-1:0] req_vec_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection. DMEM_ARB_RR_EN defined: round-robin on conflict
// (the master that is not last_owner wins); undefined: M0 always wins conflicts.
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  req_vec_t req_i,
  input  logic     last_owner_i,
  output req_vec_t gnt_o,
  output logic     winner_o
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority keeps last_owner tracked upstream but never consults it.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    winner_o = 1'b0;
    gnt_o    = '0;
    case (req_i)
      2'b01: winner_o = 1'b0;
      2'b10: winner_o = 1'b1;
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        winner_o = ~last_owner_i;
`else
        winner_o = 1'b0;
`endif
      end
      default: winner_o = 1'b0;
    endcase
    if (|req_i) begin
      gnt_o = winner_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master DMEM command arbiter with single-cycle read response routing.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (M0).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_DEPTH = 14
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  M0_REQ,
  input  logic                  M0_WE,
  input  logic [1:0]            M0_BYTE_SEL,
  input  logic                  M0_SIGN,
  input  logic [ADDR_DEPTH-1:0] M0_ADDR,
  input  logic [31:0]           M0_WDATA,
  output logic                  M0_GNT,
  output logic                  M0_RVALID,
  output logic [31:0]           M0_RDATA,

  input  logic                  M1_REQ,
  input  logic                  M1_WE,
  input  logic [1:0]            M1_BYTE_SEL,
  input  logic                  M1_SIGN,
  input  logic [ADDR_DEPTH-1:0] M1_ADDR,
  input  logic [31:0]           M1_WDATA,
  output logic                  M1_GNT,
  output logic                  M1_RVALID,
  output logic [31:0]           M1_RDATA,

  output logic                  MEM_RDEN,
  output logic                  MEM_WEN,
  output logic [1:0]            MEM_BYTE_SEL,
  output logic                  MEM_SIGN,
  output logic [ADDR_DEPTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_DIN,
  input  logic [31:0]           MEM_DOUT
);

  state_t   state_q, state_d;
  logic     owner_q, owner_d;
  logic     last_owner_q, last_owner_d;

  req_vec_t req;
  req_vec_t pick_gnt;
  req_vec_t gnt;
  logic     winner;
  logic     grant;

  logic                  win_we;
  logic [1:0]            win_byte_sel;
  logic                  win_sign;
  logic [ADDR_DEPTH-1:0] win_addr;
  logic [31:0]           win_wdata;

  logic                  rsp_valid;

  assign req = {M1_REQ, M0_REQ};

  arb_pick2 u_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .gnt_o        (pick_gnt),
    .winner_o     (winner)
  );

  // Reset masks the grant so nothing is accepted or driven to DMEM during RST.
  assign gnt    = RST ? '0 : pick_gnt;
  assign grant  = |gnt;
  assign M0_GNT = gnt[0];
  assign M1_GNT = gnt[1];

  always_comb begin
    win_we       = 1'b0;
    win_byte_sel = '0;
    win_sign     = 1'b0;
    win_addr     = '0;
    win_wdata    = '0;
    if (gnt[1]) begin
      win_we       = M1_WE;
      win_byte_sel = M1_BYTE_SEL;
      win_sign     = M1_SIGN;
      win_addr     = M1_ADDR;
      win_wdata    = M1_WDATA;
    end else if (gnt[0]) begin
      win_we       = M0_WE;
      win_byte_sel = M0_BYTE_SEL;
      win_sign     = M0_SIGN;
      win_addr     = M0_ADDR;
      win_wdata    = M0_WDATA;
    end
  end

  assign MEM_WEN      = grant &  win_we;
  assign MEM_RDEN     = grant & ~win_we;
  assign MEM_BYTE_SEL = win_byte_sel;
  assign MEM_SIGN     = win_sign;
  assign MEM_ADDR     = win_addr;
  assign MEM_DIN      = win_wdata;

  always_comb begin
    state_d      = IDLE;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if (grant) begin
      last_owner_d = winner;
      if (!win_we) begin
        state_d = RD_RESP;
        owner_d = winner;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // DMEM returns read data one cycle after the grant; steer it to the latched owner.
  assign rsp_valid = ~RST & (state_q == RD_RESP);
  assign M0_RVALID = rsp_valid & ~owner_q;
  assign M1_RVALID = rsp_valid &  owner_q;
  assign M0_RDATA  = M0_RVALID ? MEM_DOUT : 32'h0;
  assign M1_RDATA  = M1_RVALID ? MEM_DOUT : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// compared against a transaction-level arbitration model and a DMEM model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 14;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          req;
    logic          we;
    logic [1:0]    bs;
    logic          sign;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_sign, m1_req, m1_we, m1_sign;
  logic [1:0]    m0_bs, m1_bs;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_rden, mem_wen, mem_sign;
  logic [1:0]    mem_bs;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_DEPTH(AW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .M0_REQ       (m0_req),
    .M0_WE        (m0_we),
    .M0_BYTE_SEL  (m0_bs),
    .M0_SIGN      (m0_sign),
    .M0_ADDR      (m0_addr),
    .M0_WDATA     (m0_wdata),
    .M0_GNT       (m0_gnt),
    .M0_RVALID    (m0_rvalid),
    .M0_RDATA     (m0_rdata),
    .M1_REQ       (m1_req),
    .M1_WE        (m1_we),
    .M1_BYTE_SEL  (m1_bs),
    .M1_SIGN      (m1_sign),
    .M1_ADDR      (m1_addr),
    .M1_WDATA     (m1_wdata),
    .M1_GNT       (m1_gnt),
    .M1_RVALID    (m1_rvalid),
    .M1_RDATA     (m1_rdata),
    .MEM_RDEN     (mem_rden),
    .MEM_WEN      (mem_wen),
    .MEM_BYTE_SEL (mem_bs),
    .MEM_SIGN     (mem_sign),
    .MEM_ADDR     (mem_addr),
    .MEM_DIN      (mem_din),
    .MEM_DOUT     (mem_dout)
  );

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] bs, input logic sgn);
    case (bs)
      BYTE_SEL_BYTE: extract = sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      BYTE_SEL_HALF: extract = sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default:       extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [1:0] bs);
    case (bs)
      BYTE_SEL_BYTE: merge = {old[31:8], d[7:0]};
      BYTE_SEL_HALF: merge = {old[31:16], d[15:0]};
      default:       merge = d;
    endcase
  endfunction

  // DMEM: registered read, write at the edge ending the grant cycle.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wen)  mem[mem_addr] <= merge(mem[mem_addr], mem_din, mem_bs);
    if (mem_rden) mem_dout      <= extract(mem[mem_addr], mem_bs, mem_sign);
  end

  // Transaction-level expectation state.
  logic [31:0] ref_mem [int];
  logic        m_last = 1'b1;
  logic        m_pend = 1'b0;
  logic        m_pend_id = 1'b0;
  logic [31:0] m_pend_data = 32'h0;
  logic [1:0]  m_gnt;

  logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_rden, obs_wen;
  logic [31:0] obs_rd0, obs_rd1;
  logic [AW-1:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic req, input logic we, input logic [1:0] bs,
                              input logic sgn, input logic [AW-1:0] addr, input logic [31:0] wd);
    cmd_t c;
    c.req = req; c.we = we; c.bs = bs; c.sign = sgn; c.addr = addr; c.wdata = wd;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.req   = ($urandom_range(3) != 0);
    c.we    = $urandom_range(1);
    c.bs    = 2'($urandom_range(2));
    c.sign  = $urandom_range(1);
    c.addr  = AW'($urandom_range(15));
    c.wdata = $urandom;
    return c;
  endfunction

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic r, input cmd_t c0, input cmd_t c1, input string tag);
    logic        any, win, ex_rv0, ex_rv1;
    cmd_t        wc;
    logic [31:0] old;
    rst = r;
    m0_req = c0.req; m0_we = c0.we; m0_bs = c0.bs; m0_sign = c0.sign; m0_addr = c0.addr; m0_wdata = c0.wdata;
    m1_req = c1.req; m1_we = c1.we; m1_bs = c1.bs; m1_sign = c1.sign; m1_addr = c1.addr; m1_wdata = c1.wdata;
    @(negedge clk);
    any = !r && (c0.req || c1.req);
    if (c0.req && c1.req) win = RR ? ~m_last : 1'b0;
    else                  win = c1.req;
    wc = win ? c1 : c0;
    m_gnt  = any ? (win ? 2'b10 : 2'b01) : 2'b00;
    ex_rv0 = !r && m_pend && !m_pend_id;
    ex_rv1 = !r && m_pend &&  m_pend_id;

    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata; obs_rden = mem_rden; obs_wen = mem_wen; obs_addr = mem_addr;

    check({tag, ".m0_gnt"},  32'(m0_gnt),    32'(m_gnt[0]));
    check({tag, ".m1_gnt"},  32'(m1_gnt),    32'(m_gnt[1]));
    check({tag, ".rden"},    32'(mem_rden),  32'(any && !wc.we));
    check({tag, ".wen"},     32'(mem_wen),   32'(any && wc.we));
    check({tag, ".bsel"},    32'(mem_bs),    any ? 32'(wc.bs) : 32'h0);
    check({tag, ".sign"},    32'(mem_sign),  any ? 32'(wc.sign) : 32'h0);
    check({tag, ".addr"},    32'(mem_addr),  any ? 32'(wc.addr) : 32'h0);
    check({tag, ".din"},     mem_din,        any ? wc.wdata : 32'h0);
    check({tag, ".m0_rv"},   32'(m0_rvalid), 32'(ex_rv0));
    check({tag, ".m1_rv"},   32'(m1_rvalid), 32'(ex_rv1));
    check({tag, ".m0_rd"},   m0_rdata,       ex_rv0 ? m_pend_data : 32'h0);
    check({tag, ".m1_rd"},   m1_rdata,       ex_rv1 ? m_pend_data : 32'h0);

    if (r) begin
      m_pend = 1'b0;
      m_last = 1'b1;
    end else if (any) begin
      m_last    = win;
      m_pend    = !wc.we;
      m_pend_id = win;
      old       = ref_mem.exists(int'(wc.addr)) ? ref_mem[int'(wc.addr)] : 32'h0;
      if (wc.we) ref_mem[int'(wc.addr)] = merge(old, wc.wdata, wc.bs);
      else       m_pend_data = extract(old, wc.bs, wc.sign);
    end else begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmd_t idle, a, b;
    logic [3:0] exp_g0_seq;
    logic [3:0] exp_g1_seq;
    logic       prev_g0, prev_g1;
    idle = mk(1'b0, 1'b0, BYTE_SEL_WORD, 1'b0, '0, 32'h0);
    exp_g0_seq = RR ? 4'b0101 : 4'b1111;
    exp_g1_seq = ~exp_g0_seq;

    // Reset with live requests: everything must stay quiet.
    cycle(1'b1, mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd5, 32'h0),
                mk(1'b1, 1'b1, BYTE_SEL_WORD, 1'b0, 14'd6, 32'h55), "reset0");
    cycle(1'b1, idle, idle, "reset1");
    check("reset.m0_gnt", 32'(obs_g0), 32'h0);

    for (int i = 0; i < 16; i++)
      cycle(1'b0, mk(1'b1, 1'b1, BYTE_SEL_WORD, 1'b0, AW'(i), $urandom), idle, "init");

    // M0 word write then M1 read of the same address.
    cycle(1'b0, mk(1'b1, 1'b1, BYTE_SEL_WORD, 1'b0, 14'h010, 32'hDEADBEEF), idle, "raw1");
    check("raw1.m0_gnt", 32'(obs_g0), 32'h1);
    cycle(1'b0, idle, mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'h010, 32'h0), "raw2");
    check("raw2.m1_gnt", 32'(obs_g1), 32'h1);
    check("raw2.m0_rv",  32'(obs_rv0), 32'h0);
    cycle(1'b0, idle, idle, "raw3");
    check("raw3.m1_rv",  32'(obs_rv1), 32'h1);
    check("raw3.m1_rd",  obs_rd1, 32'hDEADBEEF);
    check("raw3.m0_rv",  32'(obs_rv0), 32'h0);

    // Unsigned then signed byte read of 0x12345680.
    cycle(1'b0, mk(1'b1, 1'b1, BYTE_SEL_WORD, 1'b0, 14'h020, 32'h12345680), idle, "byte_wr");
    cycle(1'b0, mk(1'b1, 1'b0, BYTE_SEL_BYTE, 1'b0, 14'h020, 32'h0), idle, "byte_u");
    cycle(1'b0, mk(1'b1, 1'b0, BYTE_SEL_BYTE, 1'b1, 14'h020, 32'h0), idle, "byte_s");
    check("byte_u.m0_rd", obs_rd0, 32'h00000080);
    cycle(1'b0, idle, idle, "byte_end");
    check("byte_s.m0_rd", obs_rd0, 32'hFFFFFF80);

    // Both masters reading continuously for four cycles from reset.
    cycle(1'b1, idle, idle, "conf_rst");
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a = mk(k < 4, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd1, 32'h0);
      b = mk(k < 4, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd2, 32'h0);
      cycle(1'b0, a, b, "conf");
      if (k < 4) begin
        check("conf.seq_g0", 32'(obs_g0), 32'(exp_g0_seq[k]));
        check("conf.seq_g1", 32'(obs_g1), 32'(exp_g1_seq[k]));
      end
      check("conf.rv0_lat", 32'(obs_rv0), 32'(prev_g0));
      check("conf.rv1_lat", 32'(obs_rv1), 32'(prev_g1));
      prev_g0 = (k < 4) && exp_g0_seq[k];
      prev_g1 = (k < 4) && exp_g1_seq[k];
    end

    // Reset in what would be the grant cycle of an M1 read.
    cycle(1'b1, idle, mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd3, 32'h0), "rst_gnt");
    check("rst_gnt.m1_gnt", 32'(obs_g1), 32'h0);
    check("rst_gnt.rden",   32'(obs_rden), 32'h0);
    cycle(1'b0, idle, idle, "rst_after");
    check("rst_after.m1_rv", 32'(obs_rv1), 32'h0);
    cycle(1'b0, mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd3, 32'h0),
                mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd4, 32'h0), "rst_conf");
    check("rst_conf.m0_gnt", 32'(obs_g0), 32'h1);
    cycle(1'b0, idle, idle, "rst_end");

    // M1 requests while M0 wins, then withdraws: nothing issued for M1.
    cycle(1'b1, idle, idle, "drop_rst");
    cycle(1'b0, mk(1'b1, 1'b1, BYTE_SEL_WORD, 1'b0, 14'd4, 32'hA5A5_0001),
                mk(1'b1, 1'b0, BYTE_SEL_WORD, 1'b0, 14'd9, 32'h0), "drop_a");
    check("drop_a.m1_gnt", 32'(obs_g1), 32'h0);
    check("drop_a.addr",   32'(obs_addr), 32'd4);
    cycle(1'b0, idle, idle, "drop_b");
    check("drop_b.rden",   32'(obs_rden), 32'h0);
    check("drop_b.m1_rv",  32'(obs_rv1), 32'h0);

    // Random traffic; a master holds its command until granted or it withdraws.
    a = rnd_cmd();
    b = rnd_cmd();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(39) == 0), a, b, "rand");
      if (!a.req || m_gnt[0] || $urandom_range(7) == 0) a = rnd_cmd();
      if (!b.req || m_gnt[1] || $urandom_range(7) == 0) b = rnd_cmd();
    end
    cycle(1'b0, idle, idle, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_DEPTH, default 14, the DMEM word-address width.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports M0_REQ / M1_REQ  input  1  each requester's command request.
REQ-005 The block SHALL have ports M0_WE / M1_WE  input  1  1 = write, 0 = read.
REQ-006 The block SHALL have ports M0_BYTE_SEL / M1_BYTE_SEL  input  2  with encoding 00 byte, 01 half, 10 word.
REQ-007 The block SHALL have ports M0_SIGN / M1_SIGN  input  1  the sign-extend flag.
REQ-008 The block SHALL have ports M0_ADDR / M1_ADDR  input  ADDR_DEPTH  the word address.
REQ-009 The block SHALL have ports M0_WDATA / M1_WDATA  input  32  the write data.
REQ-010 The block SHALL have ports M0_GNT / M1_GNT  output  1  command accepted this cycle.
REQ-011 The block SHALL have ports M0_RVALID / M1_RVALID  output  1  read data valid.
REQ-012 The block SHALL have ports M0_RDATA / M1_RDATA  output  32  read data.
REQ-013 The block SHALL have ports MEM_RDEN, MEM_WEN  output  1 each  the DMEM read and write enables.
REQ-014 The block SHALL have ports MEM_BYTE_SEL  output  2, MEM_SIGN  output  1, MEM_ADDR  output  ADDR_DEPTH, and MEM_DIN  output  32, all driven to DMEM.
REQ-015 The block SHALL have port MEM_DOUT  input  32  the DMEM registered read data (1-cycle latency).

Function
REQ-016 In any cycle with at least one REQ high, the block SHALL assert exactly one GNT, combinationally, to the arbitration winner; it SHALL never assert GNT to a requester whose REQ is low.
REQ-017 A command SHALL be accepted at the rising edge ending a cycle in which its GNT=1; a requester SHALL hold its command stable while REQ=1 and GNT=0.
REQ-018 In a grant cycle, the block SHALL drive the winner's BYTE_SEL, SIGN, ADDR and WDATA combinationally onto MEM_*, with MEM_WEN=WE and MEM_RDEN=~WE.
REQ-019 The block SHALL never assert MEM_RDEN and MEM_WEN together; with no grant, both SHALL be 0 and MEM_BYTE_SEL, MEM_SIGN, MEM_ADDR and MEM_DIN SHALL be 0.
REQ-020 The FSM SHALL have states IDLE and RD_RESP; an accepted read SHALL go to RD_RESP and latch the owner ID; any other cycle SHALL go to IDLE.
REQ-021 In RD_RESP, the owner's RVALID SHALL be 1 and its RDATA SHALL equal MEM_DOUT; otherwise, RVALID SHALL be 0 and RDATA SHALL be 0.
REQ-022 New grants SHALL be permitted in RD_RESP (back-to-back reads, one per cycle, with read latency of exactly 1 cycle after the grant).
REQ-023 A write SHALL produce no RVALID; a write to address A followed next cycle by a read of A SHALL return the written data.
REQ-024 The priority state SHALL update only in grant cycles: last_owner <= winner.
REQ-025 A requester dropping REQ before grant SHALL be legal, and no command SHALL be issued for it.

Reset
REQ-026 While RST=1, state SHALL be IDLE, last_owner SHALL be 1 (M0 wins first), and all GNT, RVALID and MEM enables SHALL be 0, with all data outputs 0.
REQ-027 RST asserted in the grant cycle of a read SHALL suppress the following RVALID; the outstanding read is dropped.

Configuration
REQ-028 When macro DMEM_ARB_RR_EN is defined, arbitration SHALL be round-robin: on a conflict, the requester that is not last_owner wins.
REQ-029 When DMEM_ARB_RR_EN is undefined, arbitration SHALL be fixed-priority with M0 always winning conflicts; last_owner SHALL still be maintained but SHALL be unused.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state_t enum (IDLE, RD_RESP), NUM_MASTERS=2, and BYTE_SEL constants BYTE_SEL_BYTE=2'b00, BYTE_SEL_HALF=2'b01 and BYTE_SEL_WORD=2'b10.
REQ-031 Sub-module arb_pick2 SHALL compute the winner from the two REQ bits and last_owner, honouring DMEM_ARB_RR_EN; dmem_arbiter SHALL hold the FSM, the mux and response routing.

Verification
REQ-032 The bench SHALL check: M0 write word 0xDEADBEEF @0x010, then M1 read @0x010 -> M0_GNT in cycle 1, M1_GNT in cycle 2, M1_RVALID=1 with M1_RDATA=0xDEADBEEF in cycle 3, and M0_RVALID=0 throughout.
REQ-033 The bench SHALL check: both requesters read continuously for 4 cycles with RR defined -> grants M0,M1,M0,M1 and each RVALID one cycle after its grant.
REQ-034 The bench SHALL check: the same stimulus with RR undefined -> M0 granted all 4 cycles and M1_GNT=0.
REQ-035 The bench SHALL check: M0 byte read unsigned @0x020 holding 0x12345680 -> M0_RDATA=0x00000080; and a signed byte read -> 0xFFFFFF80.
REQ-036 The bench SHALL check: RST=1 in the grant cycle of an M1 read -> no RVALID next cycle, all outputs 0, and the next conflict granted to M0.
REQ-037 The bench SHALL check: M1 raises then drops REQ while M0 holds the grant -> no MEM command is issued for M1.
